// File: rtl/rob_pkg.sv
// Shared defaults and the entry record for the reorder buffer.
package rob_pkg;

    localparam int ROB_REGISTER_SIZE    = 32;
    localparam int ROB_REG_ADDRESS_SIZE = 5;
    localparam int ROB_ID_SIZE          = 1;

    typedef struct packed {
        logic                            valid;
        logic                            w;
        logic [ROB_REG_ADDRESS_SIZE-1:0] address;
        logic [ROB_REGISTER_SIZE-1:0]    data;
    } rob_entry_t;

endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer slot: filled by a write, emptied by a commit clear.
module rob_entry
    import rob_pkg::*;
#(
    parameter int REGISTER_SIZE    = ROB_REGISTER_SIZE,
    parameter int REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_wr,
    input  logic                        i_w,
    input  logic [REG_ADDRESS_SIZE-1:0] i_address,
    input  logic [REGISTER_SIZE-1:0]    i_data,
    input  logic                        i_clr,
    output logic                        o_valid,
    output logic                        o_w,
    output logic [REG_ADDRESS_SIZE-1:0] o_address,
    output logic [REGISTER_SIZE-1:0]    o_data
);

    logic                        r_valid;
    logic                        r_w;
    logic [REG_ADDRESS_SIZE-1:0] r_address;
    logic [REGISTER_SIZE-1:0]    r_data;

    // A write only ever targets an empty slot and a clear only a full one,
    // so the two never coincide on the same slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_w       <= 1'b0;
            r_address <= '0;
            r_data    <= '0;
        end else if (i_wr) begin
            r_valid   <= 1'b1;
            r_w       <= i_w;
            r_address <= i_address;
            r_data    <= i_data;
        end else if (i_clr) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_w       = r_w;
    assign o_address = r_address;
    assign o_data    = r_data;

endmodule

// File: rtl/rob.sv
// Reorder buffer: two out-of-order fill ports, in-order single commit from tail.
module rob
    import rob_pkg::*;
#(
    parameter int REGISTER_SIZE    = ROB_REGISTER_SIZE,
    parameter int REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE,
    parameter int ID_SIZE          = ROB_ID_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ID_SIZE-1:0]          port1_id,
    input  logic [REG_ADDRESS_SIZE-1:0] port1_address,
    input  logic [REGISTER_SIZE-1:0]    port1_data,
    input  logic                        port1_w,
    input  logic                        port1_req,
    output logic                        port1_stall,
    input  logic [ID_SIZE-1:0]          port2_id,
    input  logic [REG_ADDRESS_SIZE-1:0] port2_address,
    input  logic [REGISTER_SIZE-1:0]    port2_data,
    input  logic                        port2_w,
    input  logic                        port2_req,
    output logic                        port2_stall,
    output logic [ID_SIZE-1:0]          tail,
    output logic                        commit_valid,
    output logic                        commit_w,
    output logic [REG_ADDRESS_SIZE-1:0] commit_address,
    output logic [REGISTER_SIZE-1:0]    commit_data
);

    localparam int DEPTH = 2 ** ID_SIZE;

    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0]            w_ent_w;
    logic [REG_ADDRESS_SIZE-1:0] w_ent_address [DEPTH];
    logic [REGISTER_SIZE-1:0]    w_ent_data    [DEPTH];

    logic [DEPTH-1:0]            w_wr;
    logic [DEPTH-1:0]            w_clr;
    logic [DEPTH-1:0]            w_wr_w;
    logic [REG_ADDRESS_SIZE-1:0] w_wr_address  [DEPTH];
    logic [REGISTER_SIZE-1:0]    w_wr_data     [DEPTH];

    logic w_stall1, w_stall2, w_acc1, w_acc2, w_sel1;

    logic [ID_SIZE-1:0]          r_tail;
    logic                        r_commit_valid;
    logic                        r_commit_w;
    logic [REG_ADDRESS_SIZE-1:0] r_commit_address;
    logic [REGISTER_SIZE-1:0]    r_commit_data;

    // Stall looks only at registered valid bits: a slot freed by commit
    // becomes fillable from the following edge.
    always_comb begin
        w_stall1 = port1_req && w_valid[port1_id];
        w_stall2 = port2_req && (w_valid[port2_id] ||
                                 (port1_req && (port1_id == port2_id)));
        w_acc1   = port1_req && !w_stall1;
        w_acc2   = port2_req && !w_stall2;
        w_sel1   = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_sel1          = w_acc1 && (port1_id == ID_SIZE'(i));
            w_wr[i]         = w_sel1 || (w_acc2 && (port2_id == ID_SIZE'(i)));
            w_wr_w[i]       = w_sel1 ? port1_w       : port2_w;
            w_wr_address[i] = w_sel1 ? port1_address : port2_address;
            w_wr_data[i]    = w_sel1 ? port1_data    : port2_data;
            w_clr[i]        = w_valid[i] && (r_tail == ID_SIZE'(i));
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        rob_entry #(
            .REGISTER_SIZE    (REGISTER_SIZE),
            .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE)
        ) u_entry (
            .clk       (clk),
            .reset     (reset),
            .i_wr      (w_wr[gi]),
            .i_w       (w_wr_w[gi]),
            .i_address (w_wr_address[gi]),
            .i_data    (w_wr_data[gi]),
            .i_clr     (w_clr[gi]),
            .o_valid   (w_valid[gi]),
            .o_w       (w_ent_w[gi]),
            .o_address (w_ent_address[gi]),
            .o_data    (w_ent_data[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tail           <= '0;
            r_commit_valid   <= 1'b0;
            r_commit_w       <= 1'b0;
            r_commit_address <= '0;
            r_commit_data    <= '0;
        end else begin
            r_commit_valid <= w_valid[r_tail];
            if (w_valid[r_tail]) begin
                r_commit_w       <= w_ent_w[r_tail];
                r_commit_address <= w_ent_address[r_tail];
                r_commit_data    <= w_ent_data[r_tail];
                r_tail           <= r_tail + ID_SIZE'(1);
            end
        end
    end

    assign port1_stall    = w_stall1;
    assign port2_stall    = w_stall2;
    assign tail           = r_tail;
    assign commit_valid   = r_commit_valid;
    assign commit_w       = r_commit_w;
    assign commit_address = r_commit_address;
    assign commit_data    = r_commit_data;

endmodule

// File: tb/tb_rob.sv
// Directed vector table plus randomized traffic against an array-based ROB model.
module tb_rob;
    import rob_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:0]  port1_id, port2_id;
    logic [4:0]  port1_address, port2_address;
    logic [31:0] port1_data, port2_data;
    logic        port1_w, port2_w, port1_req, port2_req;
    logic        port1_stall, port2_stall;
    logic [0:0]  tail;
    logic        commit_valid, commit_w;
    logic [4:0]  commit_address;
    logic [31:0] commit_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rob dut (
        .clk            (clk),
        .reset          (reset),
        .port1_id       (port1_id),
        .port1_address  (port1_address),
        .port1_data     (port1_data),
        .port1_w        (port1_w),
        .port1_req      (port1_req),
        .port1_stall    (port1_stall),
        .port2_id       (port2_id),
        .port2_address  (port2_address),
        .port2_data     (port2_data),
        .port2_w        (port2_w),
        .port2_req      (port2_req),
        .port2_stall    (port2_stall),
        .tail           (tail),
        .commit_valid   (commit_valid),
        .commit_w       (commit_w),
        .commit_address (commit_address),
        .commit_data    (commit_data)
    );

    typedef struct {
        logic        rst;
        logic        r1;  logic [0:0] id1; logic w1; logic [4:0] a1; logic [31:0] d1;
        logic        r2;  logic [0:0] id2; logic w2; logic [4:0] a2; logic [31:0] d2;
        logic        es1; logic es2;
        logic        ecv; logic ecw; logic [4:0] eca; logic [31:0] ecd;
        logic [0:0]  etail;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst,
                                input logic r1, input logic id1, input logic w1,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic r2, input logic id2, input logic w2,
                                input logic [4:0] a2, input logic [31:0] d2,
                                input logic es1, input logic es2,
                                input logic ecv, input logic ecw,
                                input logic [4:0] eca, input logic [31:0] ecd,
                                input logic etail);
        vec_t v;
        v.rst = rst; v.r1 = r1; v.id1 = id1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.r2 = r2; v.id2 = id2; v.w2 = w2; v.a2 = a2; v.d2 = d2;
        v.es1 = es1; v.es2 = es2; v.ecv = ecv; v.ecw = ecw; v.eca = eca; v.ecd = ecd;
        v.etail = etail;
        return v;
    endfunction

    task automatic drive(input logic rst,
                         input logic r1, input logic id1, input logic w1,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic r2, input logic id2, input logic w2,
                         input logic [4:0] a2, input logic [31:0] d2);
        reset = rst;
        port1_req = r1; port1_id = id1; port1_w = w1; port1_address = a1; port1_data = d1;
        port2_req = r2; port2_id = id2; port2_w = w2; port2_address = a2; port2_data = d2;
    endtask

    // Reference model state: one record per slot plus the commit pointer.
    rob_entry_t m_ent [2];
    int         m_tail;
    rob_entry_t m_commit;

    logic        p1, p2;
    logic [0:0]  rid1, rid2;
    logic        rw1, rw2;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        rrst, es1, es2;

    initial begin
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //     rst r1 id w  a   d         r2 id w  a   d          s1 s2 cv cw ca  cd        tail
        vecs.push_back(mk(1, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 0,0, 0, 0,        0));
        vecs.push_back(mk(1, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 0,0, 0, 0,        0));
        vecs.push_back(mk(0, 1,1,1, 1, 1,        0,0,0, 0, 0,         0,0, 0,0, 0, 0,        0));
        vecs.push_back(mk(0, 1,1,1, 1, 1,        0,0,0, 0, 0,         1,0, 0,0, 0, 0,        0));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        1,0,0, 0, 1,         0,0, 0,0, 0, 0,        0));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 1,0, 0, 1,        1));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 1,1, 1, 1,        0));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 0,0, 0, 0,        0));
        vecs.push_back(mk(0, 1,0,1, 3, 32'h33,   1,0,1, 4, 32'h44,    0,1, 0,0, 0, 0,        0));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        1,0,1, 4, 32'h44,    0,1, 1,1, 3, 32'h33,   1));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        1,0,1, 4, 32'h44,    0,0, 0,0, 0, 0,        1));
        vecs.push_back(mk(0, 1,1,0, 5, 32'h55,   0,0,0, 0, 0,         0,0, 0,0, 0, 0,        1));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 1,0, 5, 32'h55,   0));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 1,1, 4, 32'h44,   1));
        vecs.push_back(mk(0, 1,0,1, 6, 32'h66,   1,1,1, 7, 32'h77,    0,0, 0,0, 0, 0,        1));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 1,1, 7, 32'h77,   0));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 1,1, 6, 32'h66,   1));
        vecs.push_back(mk(0, 1,1,1, 8, 32'h88,   0,0,0, 0, 0,         0,0, 0,0, 0, 0,        1));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        1,0,1, 9, 32'h99,    0,0, 1,1, 8, 32'h88,   0));
        vecs.push_back(mk(1, 1,1,1,10, 32'h10,   1,0,1, 9, 32'h99,    0,1, 0,0, 0, 0,        0));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 0,0, 0, 0,        0));
        vecs.push_back(mk(0, 0,0,0, 0, 0,        0,0,0, 0, 0,         0,0, 0,0, 0, 0,        0));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].r1, vecs[k].id1, vecs[k].w1, vecs[k].a1, vecs[k].d1,
                  vecs[k].r2, vecs[k].id2, vecs[k].w2, vecs[k].a2, vecs[k].d2);
            #1;
            chk($sformatf("vec%0d port1_stall", k), 32'(port1_stall), 32'(vecs[k].es1));
            chk($sformatf("vec%0d port2_stall", k), 32'(port2_stall), 32'(vecs[k].es2));
            @(posedge clk); #1;
            chk($sformatf("vec%0d commit_valid", k), 32'(commit_valid), 32'(vecs[k].ecv));
            chk($sformatf("vec%0d tail", k), 32'(tail), 32'(vecs[k].etail));
            if (vecs[k].ecv) begin
                chk($sformatf("vec%0d commit_w", k), 32'(commit_w), 32'(vecs[k].ecw));
                chk($sformatf("vec%0d commit_address", k), 32'(commit_address), 32'(vecs[k].eca));
                chk($sformatf("vec%0d commit_data", k), commit_data, vecs[k].ecd);
            end
        end

        // Random phase: the table ends with an empty ROB and tail 0.
        foreach (m_ent[j]) m_ent[j] = '0;
        m_tail = 0;
        p1 = 0; p2 = 0;
        rid1 = 0; rid2 = 0; rw1 = 0; rw2 = 0; ra1 = 0; ra2 = 0; rd1 = 0; rd2 = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; rid1 = 1'($urandom); rw1 = 1'($urandom);
                ra1 = 5'($urandom); rd1 = $urandom;
            end
            if (!p2 && $urandom_range(0, 2) != 0) begin
                p2 = 1; rid2 = 1'($urandom); rw2 = 1'($urandom);
                ra2 = 5'($urandom); rd2 = $urandom;
            end
            rrst = ($urandom_range(0, 40) == 0);
            drive(rrst, p1, rid1, rw1, ra1, rd1, p2, rid2, rw2, ra2, rd2);

            es1 = p1 && m_ent[rid1].valid;
            es2 = p2 && (m_ent[rid2].valid || (p1 && rid1 == rid2));
            #1;
            chk("rnd port1_stall", 32'(port1_stall), 32'(es1));
            chk("rnd port2_stall", 32'(port2_stall), 32'(es2));

            m_commit = '0;
            if (rrst) begin
                foreach (m_ent[j]) m_ent[j].valid = 1'b0;
                m_tail = 0;
            end else begin
                if (m_ent[m_tail].valid) begin
                    m_commit = m_ent[m_tail];
                    m_ent[m_tail].valid = 1'b0;
                    m_tail = (m_tail + 1) % 2;
                end
                if (p1 && !es1) begin
                    m_ent[rid1] = '{valid: 1'b1, w: rw1, address: ra1, data: rd1};
                    p1 = 0;
                end
                if (p2 && !es2) begin
                    m_ent[rid2] = '{valid: 1'b1, w: rw2, address: ra2, data: rd2};
                    p2 = 0;
                end
            end

            @(posedge clk); #1;
            chk("rnd commit_valid", 32'(commit_valid), 32'(m_commit.valid));
            chk("rnd tail", 32'(tail), 32'(m_tail));
            if (m_commit.valid) begin
                chk("rnd commit_w", 32'(commit_w), 32'(m_commit.w));
                chk("rnd commit_address", 32'(commit_address), 32'(m_commit.address));
                chk("rnd commit_data", commit_data, m_commit.data);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
